// File: rtl/button_events.sv
// button_events: nine-button front end for the game controller.
//   Two-flop synchroniser, counter debounce and a sticky press-event flag
//   per button, plus a shared "any button" event flag.
//
//   Ports:
//     clk      pixel clock
//     rst_n    asynchronous active-low reset
//     raw_btn  raw buttons {roll,peek,hard_new,soft_new,guess,right,left,down,up}
//     ack_btn  per-button event acknowledge (same bit order)
//     ack_any  acknowledge for btn_any
//     btn      pending press events
//     btn_any  pending "some button pressed" event
//     held     debounced stable level
//
//   Optional macro BTN_AUTOREPEAT_EN: up/down/left/right (bits 0-3) re-fire
//   their event every REPEAT_PERIOD cycles once held for REPEAT_DELAY cycles.

module button_events_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536
`ifdef BTN_AUTOREPEAT_EN
 ,parameter int unsigned REPEAT_DELAY    = 12000000,
  parameter int unsigned REPEAT_PERIOD   = 3000000,
  parameter bit          REPEAT_EN       = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic ack,
  output logic held,
  output logic btn,
  output logic evt
);
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic        s1, s2;
  logic [23:0] cnt;
  logic        flip, press;

  // held flips on the edge where the mismatch run reaches DEBOUNCE_CYCLES
  assign flip  = (s2 != held) && (cnt == DB_LAST);
  assign press = flip && !held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      held <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == held) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        held <= ~held;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 24'd1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rpt
    localparam logic [23:0] RPT_LAST   = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RPT_RELOAD = 24'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [23:0] rcnt;
    logic        rpt;

    assign rpt = held && (rcnt == RPT_LAST);

    // reload keeps later repeats REPEAT_PERIOD apart without a second counter
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                rcnt <= '0;
      else if (press || !held)   rcnt <= '0;
      else if (rpt)              rcnt <= RPT_RELOAD;
      else                       rcnt <= rcnt + 24'd1;
    end

    assign evt = press | rpt;
  end else begin : g_no_rpt
    assign evt = press;
  end
`else
  assign evt = press;
`endif

  // set wins over a same-edge ack; a second event while pending is absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn <= 1'b0;
    else        btn <= evt | (btn & ~ack);
  end
endmodule

module button_events #(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned REPEAT_DELAY    = 12000000,
  parameter int unsigned REPEAT_PERIOD   = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] raw_btn,
  input  logic [8:0] ack_btn,
  input  logic       ack_any,
  output logic [8:0] btn,
  output logic       btn_any,
  output logic [8:0] held
);
  logic [8:0] evt;

  for (genvar i = 0; i < 9; i++) begin : g_lane
    button_events_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
     ,.REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (i < 4)
`endif
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_btn[i]),
      .ack   (ack_btn[i]),
      .held  (held[i]),
      .btn   (btn[i]),
      .evt   (evt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_any <= 1'b0;
    else        btn_any <= (|evt) | (btn_any & ~ack_any);
  end
endmodule

// File: tb/tb_button_events.sv
module tb_button_events;
`ifdef BTN_AUTOREPEAT_EN
  localparam int DB = 1, RD = 10, RP = 4;
`else
  localparam int DB = 4, RD = 12000000, RP = 3000000;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] raw_btn, ack_btn;
  logic       ack_any;
  logic [8:0] btn, held;
  logic       btn_any;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [8:0] m_held, m_btn;
  logic       m_any;
  logic [8:0] hist[$];     // raw samples of the last DB+1 edges, oldest first
  int         since[4];    // edges since the press event while held
  int         ev_off[$];

  button_events #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .raw_btn(raw_btn), .ack_btn(ack_btn),
    .ack_any(ack_any), .btn(btn), .btn_any(btn_any), .held(held));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    m_held = '0; m_btn = '0; m_any = 1'b0;
    hist.delete();
    for (int j = 0; j <= DB; j++) hist.push_back('0);
    for (int i = 0; i < 4; i++) since[i] = 0;
  endtask

  // A level flips once the DB samples that reached the second synchroniser
  // stage before this edge all disagree with it.
  task automatic model_edge();
    logic [8:0] flip, press, ev;
    flip = '1;
    for (int j = 0; j < DB; j++) flip &= hist[j] ^ m_held;
    press = flip & ~m_held;
    ev = press;
`ifdef BTN_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) begin
      if (press[i]) since[i] = 0;
      else if (m_held[i]) begin
        since[i]++;
        if (since[i] >= RD && (since[i] - RD) % RP == 0) ev[i] = 1'b1;
      end else since[i] = 0;
    end
`endif
    m_btn  = ev | (m_btn & ~ack_btn);
    m_any  = (|ev) | (m_any & ~ack_any);
    m_held = m_held ^ flip;
    hist.push_back(raw_btn);
    void'(hist.pop_front());
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      chk("btn", btn, m_btn);
      chk("btn_any", {8'd0, btn_any}, {8'd0, m_any});
      chk("held", held, m_held);
    end
  endtask

  task automatic release_all();
    raw_btn = '0; ack_btn = '1; ack_any = 1'b1;
    step(DB + 3);
    ack_btn = '0; ack_any = 1'b0;
  endtask

  // hold one button, ack every event, log cycle offsets of observed events
  task automatic hold_and_ack(input int idx, input int ncyc);
    ev_off.delete();
    raw_btn[idx] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      step();
      if (btn[idx]) ev_off.push_back(c);
      ack_btn[idx] = btn[idx];
    end
    ack_btn[idx] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; raw_btn = '0; ack_btn = '0; ack_any = 1'b0;
    model_reset();
    #2;
    chk("reset_btn", btn, 9'h000);
    chk("reset_held", held, 9'h000);
    chk("reset_any", {8'd0, btn_any}, 9'h000);
    step(2);
    rst_n = 1'b1;
    step(2);

    // latency: held/btn rise on the (DB+2)th edge counting the sampling edge
    raw_btn[0] = 1'b1;
    step(DB + 1);
    chk("lat_held_early", {8'd0, held[0]}, 9'h000);
    step();
    chk("lat_held", {8'd0, held[0]}, 9'h001);
    chk("lat_btn", {8'd0, btn[0]}, 9'h001);
    chk("lat_any", {8'd0, btn_any}, 9'h001);
    release_all();

    // a glitch shorter than DB never registers
    raw_btn[4] = 1'b1;
    step(DB - 1);
    raw_btn[4] = 1'b0;
    step(DB + 3);
    chk("glitch_held", {8'd0, held[4]}, 9'h000);
    chk("glitch_btn", {8'd0, btn[4]}, 9'h000);
    chk("glitch_any", {8'd0, btn_any}, 9'h000);

    // per-button ack leaves btn_any pending
    raw_btn[2] = 1'b1;
    step(DB + 2);
    ack_btn[2] = 1'b1;
    step();
    ack_btn[2] = 1'b0;
    chk("ack_btn2", {8'd0, btn[2]}, 9'h000);
    chk("ack_any_kept", {8'd0, btn_any}, 9'h001);
    ack_any = 1'b1;
    step();
    ack_any = 1'b0;
    chk("ack_any", {8'd0, btn_any}, 9'h000);

    // set wins over ack on the same edge
    raw_btn[5] = 1'b1;
    step(DB + 1);
    ack_btn[5] = 1'b1;
    step();
    ack_btn[5] = 1'b0;
    chk("set_wins", {8'd0, btn[5]}, 9'h001);

    // ack while low is not remembered
    ack_btn[1] = 1'b1;
    step();
    ack_btn[1] = 1'b0;
    raw_btn[1] = 1'b1;
    step(DB + 2);
    chk("ack_not_kept", {8'd0, btn[1]}, 9'h001);
    release_all();

    // two buttons together
    raw_btn = 9'h041;
    step(DB + 2);
    chk("dual_press", btn & 9'h041, 9'h041);
    release_all();

    // reset mid-debounce, then re-register after release
    raw_btn[3] = 1'b1;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_btn", btn, 9'h000);
    chk("rst_held", held, 9'h000);
    chk("rst_any", {8'd0, btn_any}, 9'h000);
    step(2);
    rst_n = 1'b1;
    step(DB + 1);
    chk("rereg_early", {8'd0, held[3]}, 9'h000);
    step();
    chk("rereg_held", {8'd0, held[3]}, 9'h001);
    chk("rereg_btn", {8'd0, btn[3]}, 9'h001);
    release_all();

`ifdef BTN_AUTOREPEAT_EN
    hold_and_ack(1, DB + 21);
    chk("rpt_count", 9'(ev_off.size()), 9'd4);
    if (ev_off.size() == 4) begin
      chk("rpt_first", 9'(ev_off[0]), 9'(DB + 1));
      chk("rpt_1", 9'(ev_off[1] - ev_off[0]), 9'd10);
      chk("rpt_2", 9'(ev_off[2] - ev_off[0]), 9'd14);
      chk("rpt_3", 9'(ev_off[3] - ev_off[0]), 9'd18);
    end
    release_all();
    hold_and_ack(4, 30);
    chk("norpt_count", 9'(ev_off.size()), 9'd1);
    release_all();
`else
    hold_and_ack(0, 3 * DB + 20);
    chk("single_event", 9'(ev_off.size()), 9'd1);
    release_all();
`endif

    // random bouncing buttons and acks against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 9; i++)
        if ($urandom_range(0, 7) == 0) raw_btn[i] = ~raw_btn[i];
      ack_btn = 9'($urandom & $urandom);
      ack_any = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_events.md
Name: button_events

Overview:
- Front-end stage directly upstream of the game controller.
- Synchronises and debounces the nine raw push-button inputs, and turns each press into a sticky event flag.
- Each flag stays high until the controller returns the matching acknowledge. A separate "any button" event is kept alongside the nine flags.
- Runs in the pixel-clock domain, so the controller can ignore events until it is in its button-processing window.

Parameters:
- DEBOUNCE_CYCLES, 65536: consecutive cycles a synchronised input must differ from its stable level before the level flips. Legal range 1 to 2^24-1.
- REPEAT_DELAY, 12000000: cycles from a press event to the first auto-repeat event. Used only with the optional feature.
- REPEAT_PERIOD, 3000000: cycles between subsequent auto-repeat events. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- raw_btn  in  9  raw buttons, active high; bit order {roll, peek, hard_new, soft_new, guess, right, left, down, up} (bit 0 = up)
- ack_btn  in  9  per-button acknowledge, same bit order
- ack_any  in  1  acknowledge for btn_any
- btn  out  9  pending press events, same bit order
- btn_any  out  1  pending "some button pressed" event
- held  out  9  debounced stable level of each button

Behaviour:
- Reset: asynchronous, active low. While asserted, all synchroniser flops, stable levels, counters and pending flags clear.
  - Outputs during and after reset: btn = 0, btn_any = 0, held = 0.
  - A button held through reset deassertion is treated as a fresh press after debounce.
- Synchroniser: two flops per bit (s1, s2). No logic between them.
- Debounce, per bit i, with 24-bit counter cnt[i]:
  - If s2[i] == held[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: held[i] flips and cnt[i] <= 0.
  - Else: cnt[i] increments.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES never changes held.
- Latency: for a raw input held steadily, held and btn rise after exactly DEBOUNCE_CYCLES+2 rising edges, counting the edge that first samples raw high into s1.
- Press event: fires on the edge where held[i] goes 0→1. It sets btn[i] and btn_any on that same edge. Releases (1→0) generate no event.
- Clearing:
  - btn[i] clears on an edge where ack_btn[i] = 1.
  - btn_any clears on an edge where ack_any = 1.
  - An ack while the flag is low has no effect and is not remembered.
- Simultaneous set and ack on the same edge: set wins, and the flag stays high.
- Events do not queue. A second press of a button whose flag is still pending is absorbed into the existing flag.
- Multiple buttons may be pending at once. Priority between them is the consumer's responsibility.
- Outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- When defined, applies to up, down, left and right only (bits 0-3):
  - Each has a 24-bit repeat counter that clears on every press event and whenever held[i] = 0.
  - While held[i] = 1, the counter increments each cycle.
  - When it reaches REPEAT_DELAY-1, a repeat event sets btn[i] and btn_any, and the counter reloads to REPEAT_DELAY-REPEAT_PERIOD. Subsequent events are therefore every REPEAT_PERIOD cycles.
  - Repeat events follow the same set-wins and no-queue rules as press events.
- When undefined: no repeat logic is generated, the REPEAT_* parameters are ignored, and holding a button yields exactly one event.

Test Plan:
- DEBOUNCE_CYCLES=4; raise raw_btn[0] and hold → btn[0], btn_any and held[0] rise after the 6th edge, counting the sampling edge; no further events while held.
- DEBOUNCE_CYCLES=4; pulse raw_btn[4] high for 3 cycles, then low → held[4], btn[4] and btn_any stay 0 throughout.
- btn[2] pending; assert ack_btn[2] for one cycle → btn[2] = 0 on the next edge, while btn_any stays 1 until ack_any is pulsed.
- Debounce completion for bit 5 on the same edge as ack_btn[5] = 1 → btn[5] = 1 after that edge; an ack pulse with btn[1] = 0 followed by a press → btn[1] still sets.
- Press bits 0 and 6 together → both flags set on the same edge; rst_n pulsed low mid-debounce → all outputs 0 immediately, and the held button re-registers DEBOUNCE_CYCLES+2 edges after release of reset.
- BTN_AUTOREPEAT_EN, DEBOUNCE_CYCLES=1, REPEAT_DELAY=10, REPEAT_PERIOD=4; hold raw_btn[1], acking each event → events at press, press+10, press+14, press+18; holding raw_btn[4] the same way → a single event only.
